// File: rtl/shift_fields_pipe.sv
// Two-stage elastic posit field shifter: regime/exponent unpack in S1, fraction shift and round/sticky in S2.
// Optional transaction tag enabled by defining SHIFT_FIELDS_PIPE_TAG_EN.
module shift_fields_pipe #(
  parameter int N              = 16,
  parameter int ES_MAX         = 2,
  parameter int FRAC_FULL_SIZE = 2*N,
  parameter int TE_SIZE        = $clog2(N)+ES_MAX+2,
  parameter int TAG_W          = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [$clog2(ES_MAX+1)-1:0]   in_es,
  input  logic [FRAC_FULL_SIZE-1:0]     frac_full,
  input  logic signed [TE_SIZE-1:0]     total_exp,
  input  logic                          frac_lsb_cut_off,
`ifdef SHIFT_FIELDS_PIPE_TAG_EN
  input  logic [TAG_W-1:0]              in_tag,
  output logic [TAG_W-1:0]              out_tag,
`endif
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [$clog2(N):0]     k,
  output logic [ES_MAX-1:0]             next_exp,
  output logic [N-1:0]                  frac,
  output logic                          round_bit,
  output logic                          sticky_bit,
  output logic                          k_is_oob,
  output logic                          non_zero_frac_field_size
);

  localparam int ES_W = $clog2(ES_MAX+1);
  localparam int KW   = $clog2(N)+1;
  localparam int SH_W = $clog2(FRAC_FULL_SIZE)+1;
  localparam logic signed [TE_SIZE-1:0] K_LIM = TE_SIZE'(N-2);
  localparam logic signed [TE_SIZE-1:0] N_M1  = TE_SIZE'(N-1);

  function automatic logic signed [TE_SIZE-1:0] clamp_k(input logic signed [TE_SIZE-1:0] v);
    if (v > K_LIM)       return K_LIM;
    else if (v < -K_LIM) return -K_LIM;
    return v;
  endfunction

  logic s1_load, s2_load;
  logic vld_p1_q, vld_p2_q;

  assign s2_load  = !vld_p2_q || out_ready;
  assign s1_load  = !vld_p1_q || s2_load;
  assign in_ready = s1_load;
  assign out_valid = vld_p2_q;

  // ---- S1: unpack total exponent, clamp regime, size the fields ----
  logic signed [TE_SIZE-1:0] es_s, k_raw, k_c, reg_len, avail, frac_len;
  logic [KW-1:0]             k_d;
  logic [ES_MAX-1:0]         exp_d;
  logic [ES_W-1:0]           esact_d;
  logic [SH_W-1:0]           fl_d;
  logic                      oob_d, nz_d;

  always_comb begin
    es_s     = TE_SIZE'(in_es);
    k_raw    = total_exp >>> in_es;
    exp_d    = ES_MAX'(total_exp) & ~({ES_MAX{1'b1}} << in_es);
    k_c      = clamp_k(k_raw);
    oob_d    = (k_c != k_raw);
    k_d      = KW'(k_c);
    reg_len  = k_c[TE_SIZE-1] ? TE_SIZE'(1) - k_c : k_c + TE_SIZE'(2);
    avail    = N_M1 - reg_len;
    if (avail[TE_SIZE-1])  esact_d = '0;
    else if (avail < es_s) esact_d = ES_W'(avail);
    else                   esact_d = in_es;
    frac_len = N_M1 - es_s - reg_len;
    nz_d     = !frac_len[TE_SIZE-1];
    fl_d     = SH_W'(frac_len);
  end

  logic [KW-1:0]             k_p1_q;
  logic [ES_MAX-1:0]         exp_p1_q;
  logic [ES_W-1:0]           es_p1_q, esact_p1_q;
  logic [SH_W-1:0]           fl_p1_q;
  logic                      oob_p1_q, nz_p1_q, cut_p1_q;
  logic [FRAC_FULL_SIZE-1:0] ff_p1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q   <= 1'b0;
      k_p1_q     <= '0;
      exp_p1_q   <= '0;
      es_p1_q    <= '0;
      esact_p1_q <= '0;
      fl_p1_q    <= '0;
      oob_p1_q   <= 1'b0;
      nz_p1_q    <= 1'b0;
      cut_p1_q   <= 1'b0;
      ff_p1_q    <= '0;
    end else if (s1_load) begin
      vld_p1_q <= in_valid;
      if (in_valid) begin
        k_p1_q     <= k_d;
        exp_p1_q   <= exp_d;
        es_p1_q    <= in_es;
        esact_p1_q <= esact_d;
        fl_p1_q    <= fl_d;
        oob_p1_q   <= oob_d;
        nz_p1_q    <= nz_d;
        cut_p1_q   <= frac_lsb_cut_off;
        ff_p1_q    <= frac_full;
      end
    end
  end

  // ---- S2: truncate exponent, extract fraction, derive round/sticky ----
  logic [ES_W-1:0]           drop;
  logic [ES_MAX-1:0]         next_exp_d, exp_lo;
  logic [N-1:0]              frac_d;
  logic [FRAC_FULL_SIZE-1:0] shl;
  logic                      round_d, sticky_d;

  always_comb begin
    drop       = es_p1_q - esact_p1_q;
    next_exp_d = (exp_p1_q >> drop) << drop;
    shl        = ff_p1_q << fl_p1_q;
    exp_lo     = exp_p1_q & ~({ES_MAX{1'b1}} << (drop - ES_W'(1)));
    frac_d     = '0;
    round_d    = 1'b0;
    sticky_d   = (|ff_p1_q) | cut_p1_q;
    if (nz_p1_q) begin
      // A zero-length field shifts by the full width, which yields zero.
      frac_d   = N'(ff_p1_q >> (SH_W'(FRAC_FULL_SIZE) - fl_p1_q));
      round_d  = shl[FRAC_FULL_SIZE-1];
      sticky_d = (|shl[FRAC_FULL_SIZE-2:0]) | cut_p1_q;
    end else if (drop != '0) begin
      round_d  = |(exp_p1_q & (ES_MAX'(1) << (drop - ES_W'(1))));
      sticky_d = (|exp_lo) | (|ff_p1_q) | cut_p1_q;
    end
  end

  logic [KW-1:0]     k_q;
  logic [ES_MAX-1:0] next_exp_q;
  logic [N-1:0]      frac_q;
  logic              round_q, sticky_q, oob_q, nz_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2_q   <= 1'b0;
      k_q        <= '0;
      next_exp_q <= '0;
      frac_q     <= '0;
      round_q    <= 1'b0;
      sticky_q   <= 1'b0;
      oob_q      <= 1'b0;
      nz_q       <= 1'b0;
    end else if (s2_load) begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        k_q        <= k_p1_q;
        next_exp_q <= next_exp_d;
        frac_q     <= frac_d;
        round_q    <= round_d;
        sticky_q   <= sticky_d;
        oob_q      <= oob_p1_q;
        nz_q       <= nz_p1_q;
      end
    end
  end

  assign k                        = k_q;
  assign next_exp                 = next_exp_q;
  assign frac                     = frac_q;
  assign round_bit                = round_q;
  assign sticky_bit               = sticky_q;
  assign k_is_oob                 = oob_q;
  assign non_zero_frac_field_size = nz_q;

`ifdef SHIFT_FIELDS_PIPE_TAG_EN
  logic [TAG_W-1:0] tag_p1_q, tag_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_p1_q <= '0;
      tag_q    <= '0;
    end else begin
      if (s1_load && in_valid) tag_p1_q <= in_tag;
      if (s2_load && vld_p1_q) tag_q    <= tag_p1_q;
    end
  end

  assign out_tag = tag_q;
`endif

endmodule

// File: tb/tb_shift_fields_pipe.sv
// Randomized scoreboard bench for shift_fields_pipe with directed corner cases (N=16, ES_MAX=2).
module tb_shift_fields_pipe;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  in_es;
  logic [31:0] frac_full;
  logic [7:0]  total_exp;
  logic        frac_lsb_cut_off;
  logic [4:0]  k;
  logic [1:0]  next_exp;
  logic [15:0] frac;
  logic        round_bit, sticky_bit, k_is_oob, non_zero_frac_field_size;
`ifdef SHIFT_FIELDS_PIPE_TAG_EN
  logic [3:0]  in_tag, out_tag;
  assign in_tag = 4'h0;
`endif

  shift_fields_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_es(in_es), .frac_full(frac_full), .total_exp(total_exp),
    .frac_lsb_cut_off(frac_lsb_cut_off),
`ifdef SHIFT_FIELDS_PIPE_TAG_EN
    .in_tag(in_tag), .out_tag(out_tag),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .k(k), .next_exp(next_exp),
    .frac(frac), .round_bit(round_bit), .sticky_bit(sticky_bit),
    .k_is_oob(k_is_oob), .non_zero_frac_field_size(non_zero_frac_field_size)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [26:0] exp_q[$];
  logic [27:0] held;
  bit          hold_pending = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [26:0] pack(input int kk, input int e, input int f,
                                       input bit r, input bit s, input bit o, input bit nz);
    return {kk[4:0], e[1:0], f[15:0], r, s, o, nz};
  endfunction

  function automatic logic [26:0] obs_pack();
    return {k, next_exp, frac, round_bit, sticky_bit, k_is_oob, non_zero_frac_field_size};
  endfunction

  // Reference: floor division for regime, field lengths from posit layout rules.
  function automatic logic [26:0] model(input int es, input int te, input longint ff, input bit cut);
    int p, kr, kk, ex, rl, ea, fl, drop, e, f;
    bit r, s, o, nz;
    p  = 1 << es;
    kr = (te >= 0) ? te / p : -((-te + p - 1) / p);
    ex = te - kr * p;
    kk = (kr > N-2) ? N-2 : ((kr < -(N-2)) ? -(N-2) : kr);
    o  = (kk != kr);
    rl = (kk >= 0) ? kk + 2 : 1 - kk;
    ea = N - 1 - rl;
    if (ea > es) ea = es;
    if (ea < 0)  ea = 0;
    fl   = N - 1 - es - rl;
    drop = es - ea;
    e    = (ex / (1 << drop)) * (1 << drop);
    nz   = (fl >= 0);
    if (fl >= 0) begin
      f = int'(ff / (64'd1 << (32 - fl)));
      r = ((ff / (64'd1 << (31 - fl))) % 2) != 0;
      s = ((ff % (64'd1 << (31 - fl))) != 0) || cut;
    end else begin
      f = 0;
      r = (drop > 0) ? ((ex / (1 << (drop - 1))) % 2) != 0 : 1'b0;
      s = ((drop > 1) && ((ex % (1 << (drop - 1))) != 0)) || (ff != 0) || cut;
    end
    return pack(kk, e, f, r, s, o, nz);
  endfunction

  task automatic cycle(input bit v, input bit r, input int es, input int te,
                       input logic [31:0] ff, input bit cut, output bit acc);
    @(negedge clk);
    in_valid = v; out_ready = r; in_es = es[1:0]; total_exp = te[7:0];
    frac_full = ff; frac_lsb_cut_off = cut;
    #1;
    if (hold_pending) check_eq("hold", {out_valid, obs_pack()}, held);
    hold_pending = 0;
    if (out_valid) begin
      if (r) begin
        if (exp_q.size() == 0) check_eq("spurious_out", out_valid, 1'b0);
        else check_eq("result", obs_pack(), exp_q.pop_front());
      end else begin
        hold_pending = 1;
        held = {out_valid, obs_pack()};
      end
    end
    acc = v && in_ready;
    if (acc) exp_q.push_back(model(es, te, {32'd0, ff}, cut));
  endtask

  task automatic direct(input string tag, input int es, input int te, input logic [31:0] ff,
                        input logic [26:0] want);
    bit acc;
    cycle(1, 1, es, te, ff, 0, acc);
    check_eq({tag, "_acc"}, acc, 1'b1);
    cycle(0, 1, 0, 0, 0, 0, acc);
    check_eq({tag, "_lat1"}, out_valid, 1'b0);
    cycle(0, 1, 0, 0, 0, 0, acc);
    check_eq({tag, "_vld"}, out_valid, 1'b1);
    check_eq(tag, obs_pack(), want);
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      cycle(0, 1, 0, 0, 0, 0, acc);
    end
    check_eq("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    bit acc;
    int es, te;
    logic [31:0] ff;
    bit cut, v, r;

    rst = 1; in_valid = 0; out_ready = 0; in_es = 0; total_exp = 0;
    frac_full = 0; frac_lsb_cut_off = 0;
    #12;
    check_eq("rst_vld", out_valid, 1'b0);
    check_eq("rst_data", obs_pack(), 27'd0);
    @(negedge clk);
    rst = 0;

    direct("base",     1,   0, 32'hC000_0000, pack(0, 0, 'hC00, 0, 0, 0, 1));
    direct("neg_te",   1,  -3, 32'hC000_0000, pack(-2, 1, 'h600, 0, 0, 0, 1));
    direct("pos_te",   1,   5, 32'hC000_0000, pack(2, 1, 'h300, 0, 0, 0, 1));
    direct("oob",      1,  40, 32'h1234_5678, pack(14, 0, 0, 0, 1, 1, 0));
    direct("oob_zero", 1,  40, 32'h0000_0000, pack(14, 0, 0, 0, 0, 1, 0));
    direct("round",    1,   0, 32'hC00C_0000, pack(0, 0, 'hC00, 1, 1, 0, 1));

    // Per-transaction ES, back to back.
    cycle(1, 1, 0, 5, 32'hC000_0000, 0, acc);
    cycle(1, 1, 2, 5, 32'hC000_0000, 0, acc);
    cycle(0, 1, 0, 0, 0, 0, acc);
    check_eq("es0", obs_pack(), pack(5, 0, 'hC0, 0, 0, 0, 1));
    cycle(0, 1, 0, 0, 0, 0, acc);
    check_eq("es2", obs_pack(), pack(1, 1, 'h300, 0, 0, 0, 1));
    drain();

    // Backpressure: only two transactions fit while the output is blocked.
    cycle(1, 0, 1, 3, 32'h1111_0000, 0, acc); check_eq("bp_acc0", acc, 1'b1);
    cycle(1, 0, 2, -7, 32'h2222_0000, 1, acc); check_eq("bp_acc1", acc, 1'b1);
    cycle(1, 0, 0, 9, 32'h3333_0000, 0, acc); check_eq("bp_acc2", acc, 1'b0);
    cycle(1, 0, 0, 9, 32'h3333_0000, 0, acc); check_eq("bp_acc3", acc, 1'b0);
    acc = 0;
    for (int i = 0; i < 5 && !acc; i++) cycle(1, 1, 0, 9, 32'h3333_0000, 0, acc);
    check_eq("bp_acc_resume", acc, 1'b1);
    cycle(1, 1, 1, -60, 32'h4444_0001, 0, acc);
    check_eq("bp_acc_next", acc, 1'b1);
    drain();

    // Reset with two transactions in flight.
    cycle(1, 0, 1, 5, 32'hAAAA_0000, 0, acc);
    cycle(1, 0, 1, 6, 32'h5555_0000, 0, acc);
    @(posedge clk);
    #2;
    check_eq("pre_rst_vld", out_valid, 1'b1);
    rst = 1;
    #1;
    check_eq("mid_rst_vld", out_valid, 1'b0);
    check_eq("mid_rst_data", obs_pack(), 27'd0);
    exp_q.delete();
    hold_pending = 0;
    in_valid = 0;
    @(negedge clk);
    rst = 0;
    direct("post_rst", 1, 5, 32'hC000_0000, pack(2, 1, 'h300, 0, 0, 0, 1));

    // Randomized traffic with random backpressure.
    es = $urandom_range(0, 2); te = int'($urandom_range(0, 255)) - 128;
    ff = $urandom; cut = ($urandom_range(0, 3) == 0);
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      cycle(v, r, es, te, ff, cut, acc);
      if (acc) begin
        es  = $urandom_range(0, 2);
        te  = int'($urandom_range(0, 255)) - 128;
        ff  = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
        cut = ($urandom_range(0, 3) == 0);
      end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/shift_fields_pipe.md
Name: shift_fields_pipe

Overview:
- Pipelined, runtime-configurable successor to the posit field shifter.
- Takes a full-precision fraction and a signed total exponent, then produces:
  - clamped regime k
  - truncated exponent field
  - truncated fraction field
  - round, sticky, out-of-bounds and fraction-size flags.
- ES is selectable per transaction, up to ES_MAX, so one instance serves several posit formats.
- Sits between the PPU normaliser and the posit packer, with valid/ready handshake on both sides.

Parameters:
- N, 16, posit width in bits (N >= 4).
- ES_MAX, 2, maximum exponent field size; width of the exp paths.
- FRAC_FULL_SIZE, 2*N, width of the incoming fraction.
- TE_SIZE, $clog2(N)+ES_MAX+2, width of the signed total exponent.
- TAG_W, 4, tag width; used only when SHIFT_FIELDS_PIPE_TAG_EN is defined.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept the input this cycle.
- in_es  in  $clog2(ES_MAX+1)  ES for this transaction; must be <= ES_MAX.
- frac_full  in  FRAC_FULL_SIZE  fraction, MSB-aligned, hidden bit removed.
- total_exp  in  TE_SIZE  signed total exponent.
- frac_lsb_cut_off  in  1  bits were already discarded upstream; ORed into sticky.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- k  out  $clog2(N)+1  signed regime, clamped to ±(N-2).
- next_exp  out  ES_MAX  exponent field, right-aligned to in_es, truncated bits zeroed.
- frac  out  N  fraction field, right-aligned.
- round_bit  out  1  first dropped bit.
- sticky_bit  out  1  OR of all bits below round_bit, OR frac_lsb_cut_off.
- k_is_oob  out  1  unclamped k was outside ±(N-2).
- non_zero_frac_field_size  out  1  frac_len >= 0.

Behaviour:
- Handshake and pipeline:
  - Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
  - Two elastic register stages (S1, S2). Latency is exactly 2 cycles with no stall.
  - A stage loads when it is empty or its contents move on in the same cycle.
  - in_ready = !S1_valid || (S1 advances this cycle). in_ready is combinational from out_ready; no other comb path.
  - Throughput is 1 per cycle. Order is preserved and no transaction is dropped or duplicated.
- Stalls: while out_valid && !out_ready, all outputs are held stable.
- Reset (asynchronous, rst=1):
  - S1/S2 valids and out_valid = 0; all data outputs = 0.
  - Any in-flight transactions are discarded.
  - in_ready = 1 on the first cycle after rst deasserts.
- S1 (unpack/clamp), registered:
  - k_raw = total_exp >>> in_es (arithmetic shift, floor); exp_raw = total_exp & ((1<<in_es)-1).
  - k = clamp(k_raw, -(N-2), N-2); k_is_oob = (k != k_raw).
  - reg_len = k>=0 ? k+2 : 1-k.
  - es_act = max(0, min(in_es, N-1-reg_len)).
  - frac_len = N-1-in_es-reg_len, signed, may be negative.
- S2 (shift/round), registered:
  - next_exp = (exp_raw >> (in_es-es_act)) << (in_es-es_act).
  - If frac_len >= 0:
    - frac = frac_full >> (FRAC_FULL_SIZE-frac_len); frac = 0 when frac_len = 0.
    - round_bit = frac_full[FRAC_FULL_SIZE-1-frac_len].
    - sticky_bit = |lower bits | frac_lsb_cut_off.
  - If frac_len < 0:
    - frac = 0.
    - round_bit = highest dropped exp bit.
    - sticky_bit = |remaining dropped exp bits | |frac_full | frac_lsb_cut_off.
  - If es_act = in_es and frac_len < 0 (regime alone overflows): round_bit = 0, sticky_bit = |frac_full | frac_lsb_cut_off.
- in_es = 0 is legal: next_exp = 0 and no exponent bits are dropped.

Optional Feature:
- SHIFT_FIELDS_PIPE_TAG_EN defined:
  - Adds ports in_tag (in, TAG_W) and out_tag (out, TAG_W).
  - The tag travels with its transaction through both stages and is reset to 0.
- Not defined: no tag ports and no tag registers; all other behaviour is identical.

Test Plan:
- N=16, in_es=1, total_exp=0, frac_full=0xC000_0000, out_ready=1 → 2 cycles later: k=0, next_exp=0, frac=0xC00, round=0, sticky=0, oob=0, non_zero_frac_field_size=1.
- total_exp=-3, in_es=1 → k=-2, next_exp=1, frac_len=11 (frac = top 11 bits of frac_full); total_exp=5 → k=2, next_exp=1, frac_len=10.
- total_exp=40, in_es=1 → k=14, k_is_oob=1, next_exp=0, frac=0, non_zero_frac_field_size=0; sticky=1 when frac_full != 0.
- Backpressure: 4 back-to-back inputs with out_ready=0 → in_ready drops after 2 accepts. Raise out_ready → results emerge in order, one per cycle, with held outputs stable during the stall.
- Assert rst mid-stream with 2 in flight → out_valid=0 and outputs=0 immediately; after release, a new input gives a correct result at latency 2 with no stale output.
- Same total_exp=5 with in_es=0 then in_es=2 back-to-back → k=5/next_exp=0, then k=1/next_exp=1; per-transaction ES is honoured.
